gcm_aes_out_collector: RTL
==========================

# gcm_aes_out_collector

Downstream stage of the GCM-AES controller/core pair. It consumes the core's output beats (`Out_data`, `Out_vld`, `Tag_vld`, `Out_data_size`, `Out_last_word`) and separates message/ciphertext blocks from the authentication tag. Data blocks are buffered in a show-ahead FIFO that the CPU drains, and the tag is captured and compared against a CPU-supplied expected tag. It also reports byte count, completion and overflow status to the CPU.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `AW`, default 3: log2(`DEPTH`).
- `clk`  in  1  clock, rising edge.
- `clrn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a new message and flushes all state.
- `out_data`  in  128  data block or tag from the core.
- `out_vld`  in  1  `out_data` valid.
- `tag_vld`  in  1  when set together with `out_vld`, the beat is the tag.
- `out_data_size`  in  4  valid bytes minus 1 (0 = 1 byte, 15 = 16 bytes).
- `out_last_word`  in  1  last data beat of the message.
- `exp_tag`  in  128  expected tag; must be held stable while `tag_valid` is high.
- `rd_en`  in  1  pop the FIFO head.
- `rd_data`  out  128  FIFO head data.
- `rd_size`  out  4  FIFO head size.
- `rd_last`  out  1  FIFO head last flag.
- `rd_empty`  out  1  FIFO is empty.
- `fill`  out  AW+1  FIFO occupancy.
- `tag`  out  128  captured tag.
- `tag_valid`  out  1  `tag` holds the tag for the current message.
- `tag_match`  out  1  `tag_valid` AND (`tag` == `exp_tag`).
- `byte_count`  out  16  data bytes received; saturates at 16'hFFFF.
- `overflow`  out  1  sticky: a data beat was dropped.
- `busy`  out  1  state is COLLECT or TAG_WAIT.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- Beat classification:
  - Tag beat: `out_vld` & `tag_vld`. It is never pushed to the FIFO.
  - Data beat: `out_vld` & !`tag_vld`.
- States: IDLE, COLLECT, TAG_WAIT, DONE.
- IDLE: all beats are ignored. `start` moves to COLLECT.
- COLLECT:
  - Each data beat pushes {data, size, last} and adds `out_data_size`+1 to `byte_count`.
  - A data beat with `out_last_word` set moves to TAG_WAIT.
  - A tag beat (zero-length message) captures the tag and moves to DONE.
- TAG_WAIT:
  - A tag beat captures the tag and moves to DONE.
  - Data beats are dropped and set `overflow`.
- DONE: holds until `start`. Beats are ignored. The FIFO can still be drained.
- `start` in any state, including mid-message:
  - Flushes the FIFO.
  - Clears `tag_valid`, `byte_count` and `overflow`.
  - Enters COLLECT.
  - A beat arriving in the same cycle as `start` is ignored.
- FIFO rules:
  - Push when full without a pop in the same cycle: the beat is dropped and `overflow` is set; the byte count is not updated.
  - Push and pop in the same cycle when full: both take effect.
  - Pop when empty: ignored; `rd_*` outputs are don't-care.
  - Pointers are AW+1 bits and wrap naturally. Full = MSBs differ and lower AW bits are equal.
- Reset values:
  - State = IDLE, FIFO empty, `rd_empty` = 1, `fill` = 0.
  - `tag` = 0, `tag_valid` = 0, `tag_match` = 0.
  - `byte_count` = 0, `overflow` = 0, `busy` = 0, `done` = 0.
  - `rd_data`, `rd_size` and `rd_last` read as 0.

## Timing
- Push to `rd_empty` low: 1 cycle; the head is visible in the cycle after the pushing edge.
- `rd_data`, `rd_size` and `rd_last` are combinational from the head entry (show-ahead). Pop takes effect at the edge where `rd_en` is high; the next head is visible after that edge.
- Tag beat at edge N:
  - `tag` and `tag_valid` are valid after edge N.
  - `done` is high for the single cycle after edge N.
  - `tag_match` is combinational from `tag`, `tag_valid` and `exp_tag`.
- `byte_count`, `fill` and `overflow` are registered and update at the beat's edge.
- The block accepts one beat per cycle and never back-pressures the core.

## Structure
- Shared package `gcm_aes_pkg`:
  - State encoding for this block.
  - `GCM_BLK_W` = 128, `GCM_SIZE_W` = 4.
  - FIFO entry width = 133 (`GCM_BLK_W` + `GCM_SIZE_W` + 1).
- Sub-module `gcm_out_fifo`: parameterized show-ahead FIFO with synchronous flush, full/empty/fill outputs and the same-cycle push/pop rules above.
- The top level holds the FSM, beat classifier, byte counter, tag register and comparator.

## Test plan
- Data beats with sizes 15/15/15/11, the last beat flagged, then a tag beat 5bc94fbc3221a5db94fae95ae7121a47 with `exp_tag` equal -> 4 FIFO entries, `byte_count` = 60, one `done` pulse, `tag_match` = 1.
- Same sequence with `exp_tag` bit 0 flipped -> `tag_valid` = 1, `tag_match` = 0.
- DEPTH = 8, 9 data beats with no reads -> `fill` = 8, `overflow` = 1, `byte_count` counts 8 beats only. Then push and pop in the same cycle while full -> both occur, `fill` stays 8.
- Tag beat immediately after `start` -> DONE, FIFO empty, `byte_count` = 0.
- `start` after 2 data beats -> FIFO flushed, `byte_count` = 0, state COLLECT; a beat in the same cycle as `start` is ignored.
- Assert `clrn` mid-message and pop an empty FIFO -> all outputs return to their reset values; the empty pop leaves `fill` = 0.

Source files
------------

// File: rtl/gcm_aes_pkg.sv
// Shared definitions for the GCM-AES output collector.
//   GCM_BLK_W / GCM_SIZE_W : block and size field widths
//   gcm_ent_t              : FIFO entry {data, size, last}, 133 bits
//   ST_*                   : collector FSM state encodings
package gcm_aes_pkg;

    localparam int GCM_BLK_W  = 128;
    localparam int GCM_SIZE_W = 4;
    localparam int GCM_ENT_W  = GCM_BLK_W + GCM_SIZE_W + 1;

    typedef struct packed {
        logic [GCM_BLK_W-1:0]  data;
        logic [GCM_SIZE_W-1:0] size;
        logic                  last;
    } gcm_ent_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_TAG_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/gcm_aes_out_collector_if.sv
// Core-to-collector output beat bus.
//   out_data      : data block or tag
//   out_vld       : beat valid
//   tag_vld       : beat is the tag (qualified by out_vld)
//   out_data_size : valid bytes minus 1
//   out_last_word : last data beat of the message
// master = core side (drives), slave = collector side (receives).
interface gcm_aes_out_collector_if;
    import gcm_aes_pkg::*;

    logic [GCM_BLK_W-1:0]  out_data;
    logic                  out_vld;
    logic                  tag_vld;
    logic [GCM_SIZE_W-1:0] out_data_size;
    logic                  out_last_word;

    modport master (
        output out_data, out_vld, tag_vld, out_data_size, out_last_word
    );

    modport slave (
        input  out_data, out_vld, tag_vld, out_data_size, out_last_word
    );

endinterface

// File: rtl/gcm_out_fifo.sv
// Show-ahead FIFO with synchronous flush.
//   clk, clrn : clock, async active-low reset
//   flush_i   : empties the FIFO (overrides push/pop)
//   push_i    : write wdata_i; dropped when full unless a pop occurs too
//   pop_i     : remove head; ignored when empty
//   rdata_o   : head entry (combinational), zero when empty
//   empty_o, full_o, fill_o : status
module gcm_out_fifo #(
    parameter int W     = 133,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [AW:0]  fill_o
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fill_o  = wptr_q - rptr_q;

    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_ONE;
            if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/gcm_aes_out_collector.sv
// GCM-AES output collector: splits core output beats into data blocks
// (buffered in a show-ahead FIFO for the CPU) and the authentication tag
// (captured and compared against exp_tag).
//   clk, clrn       : clock, async active-low reset
//   start           : begin new message, flush all state
//   beat            : core output beat bus (slave side)
//   exp_tag         : CPU-supplied expected tag
//   rd_en           : pop FIFO head
//   rd_data/size/last, rd_empty, fill : FIFO head and status
//   tag, tag_valid, tag_match         : captured tag and comparison
//   byte_count      : saturating data byte count
//   overflow        : sticky dropped-beat flag
//   busy, done      : COLLECT/TAG_WAIT indicator, DONE-entry pulse
module gcm_aes_out_collector
    import gcm_aes_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   start,
    gcm_aes_out_collector_if.slave beat,
    input  logic [GCM_BLK_W-1:0]   exp_tag,
    input  logic                   rd_en,
    output logic [GCM_BLK_W-1:0]   rd_data,
    output logic [GCM_SIZE_W-1:0]  rd_size,
    output logic                   rd_last,
    output logic                   rd_empty,
    output logic [AW:0]            fill,
    output logic [GCM_BLK_W-1:0]   tag,
    output logic                   tag_valid,
    output logic                   tag_match,
    output logic [15:0]            byte_count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   done
);

    logic [1:0]           state_q, state_d;
    logic [GCM_BLK_W-1:0] tag_q, tag_d;
    logic                 tag_valid_q, tag_valid_d;
    logic [15:0]          byte_count_q, byte_count_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic        data_beat, tag_beat;
    logic        push_req, push_ok;
    logic        fifo_full, fifo_empty;
    logic [16:0] bc_sum;
    gcm_ent_t    wr_ent, rd_ent;

    assign data_beat = beat.out_vld & ~beat.tag_vld;
    assign tag_beat  = beat.out_vld &  beat.tag_vld;

    // Beats coinciding with start belong to no message and are ignored.
    assign push_req = ~start & data_beat & (state_q == ST_COLLECT);
    // Mirrors the FIFO's own accept rule so the byte count tracks real pushes.
    assign push_ok  = push_req & (~fifo_full | rd_en);

    assign wr_ent.data = beat.out_data;
    assign wr_ent.size = beat.out_data_size;
    assign wr_ent.last = beat.out_last_word;

    assign bc_sum = {1'b0, byte_count_q} + 17'(beat.out_data_size) + 17'd1;

    gcm_out_fifo #(
        .W     (GCM_ENT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .flush_i (start),
        .push_i  (push_req),
        .pop_i   (rd_en),
        .wdata_i (wr_ent),
        .rdata_o (rd_ent),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .fill_o  (fill)
    );

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;
        if (start) begin
            state_d      = ST_COLLECT;
            tag_valid_d  = 1'b0;
            byte_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (push_ok)
                byte_count_d = bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
            if (push_req && !push_ok)
                overflow_d = 1'b1;
            case (state_q)
                ST_COLLECT: begin
                    if (data_beat && beat.out_last_word) begin
                        state_d = ST_TAG_WAIT;
                    end else if (tag_beat) begin
                        tag_d       = beat.out_data;
                        tag_valid_d = 1'b1;
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                    end
                end
                ST_TAG_WAIT: begin
                    if (data_beat) begin
                        overflow_d = 1'b1;
                    end else if (tag_beat) begin
                        tag_d       = beat.out_data;
                        tag_valid_d = 1'b1;
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    assign rd_data    = rd_ent.data;
    assign rd_size    = rd_ent.size;
    assign rd_last    = rd_ent.last;
    assign rd_empty   = fifo_empty;
    assign tag        = tag_q;
    assign tag_valid  = tag_valid_q;
    assign tag_match  = tag_valid_q && (tag_q == exp_tag);
    assign byte_count = byte_count_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_TAG_WAIT);
    assign done       = done_q;

endmodule
